mcpu_sim_ctrl: RTL
==================

# mcpu_sim_ctrl

Synthesizable run controller for MCPU simulation and FPGA bring-up. Sits between the board or bench clock/reset and the core wrapper. It generates a stretched core reset and drives per-channel `meminput` words. It monitors `memoutput` channels for end-of-test signatures and reports pass, fail or timeout with a cycle count. It generalises the fixed single-channel, fixed-length harness to N channels, programmable input values, a reset hold and run-length limits.

## Interface
- `WIDTH`, 32: data width of each memory I/O channel.
- `NCHAN`, 1: number of meminput/memoutput channels (1..8).
- `RESET_CYCLES`, 5: cycles `core_rst_n` is held low after leaving reset. Must be ≥1.
- `MAX_CYCLES`, 20000: run cycles before timeout. 0 disables timeout.
- `PASS_MAGIC`, 32'hC001D00D: memoutput value signalling pass (low WIDTH bits used).
- `FAIL_MAGIC`, 32'hDEADDEAD: memoutput value signalling fail.
- `INPUT_DEFAULT`, 5: reset value of every meminput channel.

Ports:
- `clkrst_core_clk`, in, 1: single clock. All logic is on its rising edge.
- `clkrst_core_rst`, in, 1: synchronous, active-high reset.
- `run_en`, in, 1: level. While low in RUN, the cycle counter and timeout freeze.
- `cfg_we`, in, 1: write strobe for meminput registers.
- `cfg_chan`, in, 3: channel index for `cfg_we`. Indices ≥ NCHAN are ignored.
- `cfg_data`, in, WIDTH: value for the addressed channel.
- `memoutput`, in, NCHAN*WIDTH: core output words, channel i at bits [i*WIDTH +: WIDTH].
- `memoutput_valid`, in, NCHAN: per-channel qualifier. A word is only inspected when its valid bit is set.
- `core_rst_n`, out, 1: active-low reset to the core, registered.
- `meminput`, out, NCHAN*WIDTH: registered per-channel input words.
- `cycle_count`, out, 32: RUN cycles counted. Saturates at 32'hFFFFFFFF.
- `last_out`, out, NCHAN*WIDTH: last valid word captured per channel.
- `done`, `pass`, `fail`, `timeout`, out, 1 each: sticky status.

## Operation
- States are HOLD, RUN and END, with a `hold_cnt` of width clog2(RESET_CYCLES+1).
- Reset (`clkrst_core_rst`=1) sets:
  - state HOLD, hold_cnt 0;
  - `core_rst_n`=0, `cycle_count`=0, `last_out`=0;
  - all meminput channels = INPUT_DEFAULT;
  - done/pass/fail/timeout = 0.
- HOLD: hold_cnt increments each cycle. When it reaches RESET_CYCLES-1, go to RUN and register `core_rst_n`=1 on the same edge.
- RUN, per cycle with `run_en`=1:
  - `cycle_count` increments, saturating.
  - For each channel with its valid bit set, `last_out` captures the word.
  - If any valid channel equals FAIL_MAGIC: set fail and done, go to END.
  - Otherwise, if any valid channel equals PASS_MAGIC: set pass and done, go to END.
  - Otherwise, if MAX_CYCLES≠0 and the incremented count equals MAX_CYCLES: set timeout and done, go to END.
- Priority: FAIL over PASS over timeout. A magic word arriving on the timeout cycle is reported as that magic, not as timeout.
- RUN with `run_en`=0: count frozen, no timeout check. Valid words are still captured and magic checks are still applied.
- END:
  - `core_rst_n` stays 1 (core free-runs for waveform inspection).
  - The counter stops and status is frozen.
  - `last_out` keeps capturing.
  - Only reset leaves END.
- `cfg_we` writes meminput[cfg_chan] in any state, taking effect the next cycle. A write issued in the same cycle as reset is dropped; reset wins.
- Reset asserted mid-RUN or in END returns to HOLD. `core_rst_n` drops the next cycle and the full reset stretch is reapplied.
- Exactly one of pass/fail/timeout is set whenever done=1.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- The first edge after reset deasserts sees `core_rst_n`=0. `core_rst_n` rises after exactly RESET_CYCLES edges with reset low.
- Magic detection latency is 1 cycle: memoutput valid at edge k gives done=1 after edge k.
- `cycle_count` equals the number of RUN edges with `run_en`=1, counting the edge that caused END.
- Status bits are stable from the assertion edge until the next reset.

## Test plan
- Default params, reset high 3 cycles then low → `core_rst_n`=0 for 5 edges, then 1. meminput=5, cycle_count=0 at RUN entry.
- Channel 0 valid with C001D00D at the 100th RUN cycle → next cycle done=1, pass=1, fail=0, cycle_count=100, last_out[0]=C001D00D. Status holds for 50 more cycles.
- NCHAN=2, same cycle ch0=C001D00D and ch1=DEADDEAD, both valid → fail=1, pass=0. Separately, DEADDEAD with valid=0 → ignored, run continues.
- MAX_CYCLES=10, no magic → timeout=1, done=1 after the 10th RUN cycle, cycle_count=10. Run again with PASS_MAGIC on cycle 10 → pass=1, timeout=0.
- `run_en` low for 20 cycles in RUN with MAX_CYCLES=10 → count stays frozen. Raise it again and timeout fires after 10 counted cycles.
- Reset pulsed in END after a cfg write of ch0=0x1234 → status cleared, meminput=5, `core_rst_n` low 5 cycles. A cfg_we concurrent with reset is dropped; cfg_chan=7 with NCHAN=2 leaves meminput unchanged.

Source files
------------

// File: rtl/mcpu_sim_ctrl.sv
// Run controller for MCPU simulation/bring-up: stretches core reset, drives
// per-channel meminput words and watches memoutput for pass/fail/timeout.
//
// state  | meaning
// S_HOLD | core held in reset, hold_cnt counting the stretch
// S_RUN  | core running, cycle counter and magic/timeout checks active
// S_END  | verdict latched, core free-runs, only reset leaves
module mcpu_sim_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned NCHAN         = 1,
    parameter int unsigned RESET_CYCLES  = 5,
    parameter int unsigned MAX_CYCLES    = 20000,
    parameter logic [31:0] PASS_MAGIC    = 32'hC001D00D,
    parameter logic [31:0] FAIL_MAGIC    = 32'hDEADDEAD,
    parameter logic [31:0] INPUT_DEFAULT = 32'd5
) (
    input  logic                   clkrst_core_clk,
    input  logic                   clkrst_core_rst,
    input  logic                   run_en,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_chan,
    input  logic [WIDTH-1:0]       cfg_data,
    input  logic [NCHAN*WIDTH-1:0] memoutput,
    input  logic [NCHAN-1:0]       memoutput_valid,
    output logic                   core_rst_n,
    output logic [NCHAN*WIDTH-1:0] meminput,
    output logic [31:0]            cycle_count,
    output logic [NCHAN*WIDTH-1:0] last_out,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout
);

    localparam int unsigned      HW        = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [WIDTH-1:0] PASS_W    = WIDTH'(PASS_MAGIC);
    localparam logic [WIDTH-1:0] FAIL_W    = WIDTH'(FAIL_MAGIC);
    localparam logic [WIDTH-1:0] INPUT_W   = WIDTH'(INPUT_DEFAULT);
    localparam logic [31:0]      MAX_W     = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_END} state_t;

    state_t                        state_q, state_d;
    logic [HW-1:0]                 hold_cnt_q, hold_cnt_d;
    logic                          core_rst_n_q, core_rst_n_d;
    logic [31:0]                   cycle_count_q, cycle_count_d;
    logic [NCHAN-1:0][WIDTH-1:0]   meminput_q, meminput_d;
    logic [NCHAN-1:0][WIDTH-1:0]   last_out_q, last_out_d;
    logic                          done_q, done_d;
    logic                          pass_q, pass_d;
    logic                          fail_q, fail_d;
    logic                          timeout_q, timeout_d;

    logic [NCHAN-1:0][WIDTH-1:0]   mo_w;
    logic [31:0]                   cnt_inc;
    logic                          any_pass;
    logic                          any_fail;

    assign mo_w = memoutput;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        core_rst_n_d  = core_rst_n_q;
        cycle_count_d = cycle_count_q;
        meminput_d    = meminput_q;
        last_out_d    = last_out_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        any_pass      = 1'b0;
        any_fail      = 1'b0;
        cnt_inc       = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                         : cycle_count_q + 32'd1;

        for (int i = 0; i < NCHAN; i++) begin
            if (cfg_we && (cfg_chan == 3'(i))) begin
                meminput_d[i] = cfg_data;
            end
            // Words are only meaningful once the core is out of reset.
            if (memoutput_valid[i] && (state_q != S_HOLD)) begin
                last_out_d[i] = mo_w[i];
                any_pass      = any_pass | (mo_w[i] == PASS_W);
                any_fail      = any_fail | (mo_w[i] == FAIL_W);
            end
        end

        case (state_q)
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = S_RUN;
                    core_rst_n_d = 1'b1;
                end
            end
            S_RUN: begin
                if (run_en) begin
                    cycle_count_d = cnt_inc;
                end
                if (any_fail) begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_END;
                end else if (any_pass) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_END;
                end else if (run_en && (MAX_CYCLES != 0) && (cnt_inc == MAX_W)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_END;
                end
            end
            S_END: begin
                state_d = S_END;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            core_rst_n_q  <= 1'b0;
            cycle_count_q <= '0;
            meminput_q    <= {NCHAN{INPUT_W}};
            last_out_q    <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            core_rst_n_q  <= core_rst_n_d;
            cycle_count_q <= cycle_count_d;
            meminput_q    <= meminput_d;
            last_out_q    <= last_out_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign meminput    = meminput_q;
    assign cycle_count = cycle_count_q;
    assign last_out    = last_out_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;

endmodule
